// File: rtl/note_player_pkg.sv
// note_player_pkg: shared widths and FSM state encoding for the note player
package note_player_pkg;
  localparam int NOTE_W   = 6;
  localparam int DUR_W    = 6;
  localparam int PHASE_W  = 20;
  localparam int SAMPLE_W = 16;
  typedef enum logic {IDLE = 1'b0, PLAYING = 1'b1} state_e;
endpackage

// File: rtl/note_step_rom.sv
// note_step_rom: combinational 64x20 phase-step table (note_i -> step_o); entry 0 is a rest, entry 49 is A440
module note_step_rom
  import note_player_pkg::*;
(
  input  logic [NOTE_W-1:0]  note_i,
  output logic [PHASE_W-1:0] step_o
);
  localparam logic [PHASE_W-1:0] STEP [64] = '{
    20'd0,
    20'd601,   20'd636,   20'd674,   20'd714,   20'd757,   20'd802,
    20'd850,   20'd900,   20'd954,   20'd1010,  20'd1070,  20'd1134,
    20'd1201,  20'd1273,  20'd1349,  20'd1429,  20'd1514,  20'd1604,
    20'd1699,  20'd1800,  20'd1907,  20'd2021,  20'd2141,  20'd2268,
    20'd2403,  20'd2546,  20'd2697,  20'd2858,  20'd3028,  20'd3208,
    20'd3398,  20'd3600,  20'd3815,  20'd4041,  20'd4282,  20'd4536,
    20'd4806,  20'd5092,  20'd5395,  20'd5715,  20'd6055,  20'd6415,
    20'd6797,  20'd7201,  20'd7629,  20'd8083,  20'd8563,  20'd9072,
    20'd9612,  20'd10184, 20'd10789, 20'd11431, 20'd12110, 20'd12830,
    20'd13593, 20'd14402, 20'd15258, 20'd16165, 20'd17127, 20'd18145,
    20'd19224, 20'd20367, 20'd21578
  };
  assign step_o = STEP[note_i];
endmodule

// File: rtl/note_player.sv
// note_player: plays one note as a triangle wave (in: clk reset play note duration new_note beat generate_next_sample; out: note_done sample_out new_sample_ready)
module note_player
  import note_player_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       play,
  input  logic [NOTE_W-1:0]          note,
  input  logic [DUR_W-1:0]           duration,
  input  logic                       new_note,
  input  logic                       beat,
  input  logic                       generate_next_sample,
  output logic                       note_done,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       new_sample_ready
);
  state_e                     state_q, state_d;
  logic [NOTE_W-1:0]          note_q, note_d;
  logic [DUR_W-1:0]           count_q, count_d;
  logic [PHASE_W-1:0]         phase_q, phase_d, step;
  logic signed [SAMPLE_W-1:0] sample_q, sample_d;
  logic                       done_q, done_d, ready_q, ready_d, run;
  logic [SAMPLE_W-1:0]        tri_mag;
  note_step_rom u_rom (.note_i(note_q), .step_o(step));
  assign run = (state_q == PLAYING) && play;
  assign tri_mag = phase_q[19] ? ~phase_q[18:3] : phase_q[18:3];
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      note_q   <= '0;
      count_q  <= '0;
      phase_q  <= '0;
      sample_q <= '0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      note_q   <= note_d;
      count_q  <= count_d;
      phase_q  <= phase_d;
      sample_q <= sample_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (new_note) state_d = PLAYING;
    else if (run && count_q == '0) state_d = IDLE;
  end
  always_comb begin
    note_d   = new_note ? note : note_q;
    count_d  = new_note ? duration : (run && beat && count_q != '0) ? count_q - 1'b1 : count_q;
    phase_d  = new_note ? '0 : (run && generate_next_sample) ? phase_q + step : phase_q;
    done_d   = !new_note && run && count_q == '0;
    sample_d = !generate_next_sample ? sample_q : (run && note_q != '0) ? $signed(tri_mag - 16'h8000) : '0;
    ready_d  = generate_next_sample;
  end
  assign note_done        = done_q;
  assign sample_out       = sample_q;
  assign new_sample_ready = ready_q;
endmodule

// File: tb/tb_note_player.sv
// tb_note_player: directed scoreboard bench for note_player
module tb_note_player;
  logic        clk = 1'b0;
  logic        reset = 1'b1, play = 1'b0, new_note = 1'b0, beat = 1'b0, gen = 1'b0;
  logic [5:0]  note = '0, duration = '0;
  logic        note_done, new_sample_ready;
  logic [15:0] sample_out;
  int          checks = 0, failures = 0, dones = 0, d0;
  logic [15:0] sq[$];
  logic        m_act = 1'b0, prev_done = 1'b0;
  logic [5:0]  m_note = '0, m_count = '0;
  logic [19:0] m_phase = '0;
  always #5 clk = ~clk;
  note_player dut (
    .clk(clk), .reset(reset), .play(play), .note(note), .duration(duration),
    .new_note(new_note), .beat(beat), .generate_next_sample(gen),
    .note_done(note_done), .sample_out(sample_out), .new_sample_ready(new_sample_ready)
  );
  function automatic logic [19:0] step_of(logic [5:0] n);
    real v;
    if (n == 6'd0) return 20'd0;
    v = 440.0 * (2.0 ** ((real'(n) - 49.0) / 12.0)) * 1048576.0 / 48000.0;
    return 20'($rtoi(v + 0.5));
  endfunction
  function automatic logic [15:0] tri_of(logic [19:0] p);
    return p[19] ? ~p[18:3] : p[18:3];
  endfunction
  task automatic chk(string tag, logic [19:0] obs, logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    logic run, exp_done, exp_rdy, was_rst;
    run      = m_act && play;
    exp_done = !reset && !new_note && run && m_count == 6'd0;
    exp_rdy  = !reset && gen;
    was_rst  = reset;
    if (exp_rdy) sq.push_back((run && m_note != 6'd0) ? tri_of(m_phase) - 16'h8000 : 16'h0);
    if (reset) begin
      m_act = 1'b0; m_note = '0; m_count = '0; m_phase = '0;
    end else if (new_note) begin
      m_act = 1'b1; m_note = note; m_count = duration; m_phase = '0;
    end else if (run) begin
      if (gen) m_phase = m_phase + step_of(m_note);
      if (m_count == 6'd0) m_act = 1'b0;
      else if (beat) m_count = m_count - 6'd1;
    end
    @(posedge clk);
    #1;
    new_note = 1'b0; beat = 1'b0; gen = 1'b0;
    chk("note_done", {19'd0, note_done}, {19'd0, exp_done});
    chk("done_twice", {19'd0, note_done & prev_done}, 20'd0);
    chk("ready", {19'd0, new_sample_ready}, {19'd0, exp_rdy});
    if (new_sample_ready && sq.size() > 0) chk("sample", {4'd0, sample_out}, {4'd0, sq.pop_front()});
    if (was_rst) chk("rst_sample", {4'd0, sample_out}, 20'd0);
    prev_done = note_done;
    dones += int'(note_done);
  endtask
  task automatic load(input logic [5:0] n, input logic [5:0] d);
    note = n; duration = d; new_note = 1'b1;
    cyc();
  endtask
  task automatic gen_pulse();
    gen = 1'b1; cyc(); cyc();
  endtask
  task automatic beat_pulse();
    beat = 1'b1; cyc(); cyc();
  endtask
  initial begin
    cyc();
    reset = 1'b0;
    cyc();
    play = 1'b1;
    d0 = dones;
    load(6'd49, 6'd3);
    beat_pulse();
    beat_pulse();
    beat = 1'b1;
    cyc();
    chk("r34_not_yet", {19'd0, note_done}, 20'd0);
    cyc();
    chk("r34_done", {19'd0, note_done}, 20'd1);
    repeat (3) cyc();
    chk("r34_count", 20'(dones - d0), 20'd1);
    gen_pulse();
    d0 = dones;
    load(6'd49, 6'd0);
    cyc();
    chk("r35_done", {19'd0, note_done}, 20'd1);
    gen_pulse();
    gen_pulse();
    chk("r35_silent", {4'd0, sample_out}, 20'd0);
    load(6'd49, 6'd3);
    gen = 1'b1;
    cyc();
    chk("r36_first", {4'd0, sample_out}, 20'h08000);
    cyc();
    repeat (3) gen_pulse();
    gen = 1'b1;
    cyc();
    chk("r36_sample", {4'd0, sample_out}, 20'h092C6);
    cyc();
    play = 1'b0;
    gen_pulse();
    chk("r37_pause_sample", {4'd0, sample_out}, 20'd0);
    d0 = dones;
    repeat (5) beat_pulse();
    play = 1'b1;
    gen_pulse();
    repeat (3) beat_pulse();
    cyc();
    chk("r37_count_held", 20'(dones - d0), 20'd1);
    d0 = dones;
    load(6'd37, 6'd2);
    gen_pulse();
    beat_pulse();
    note = 6'd20; duration = 6'd2; new_note = 1'b1; beat = 1'b1;
    cyc();
    beat_pulse();
    cyc();
    chk("r38_no_abort_done", 20'(dones - d0), 20'd0);
    beat_pulse();
    cyc();
    chk("r38_done", 20'(dones - d0), 20'd1);
    d0 = dones;
    load(6'd25, 6'd3);
    beat_pulse();
    gen_pulse();
    reset = 1'b1; gen = 1'b1; beat = 1'b1;
    cyc();
    chk("r39_ready", {19'd0, new_sample_ready}, 20'd0);
    reset = 1'b0;
    repeat (8) beat_pulse();
    chk("r39_no_done", 20'(dones - d0), 20'd0);
    d0 = dones;
    load(6'd0, 6'd1);
    gen_pulse();
    beat_pulse();
    cyc();
    chk("r25_rest_done", 20'(dones - d0), 20'd1);
    load(6'd63, 6'd40);
    repeat (60) gen_pulse();
    repeat (45) beat_pulse();
    chk("sq_drained", 20'(sq.size()), 20'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/note_player.md
NOTE_PLAYER -- requirements
Module: note_player

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port play  input  1  high = run; low = pause (countdown and phase frozen).
REQ-004 SHALL have port note  input  6  note code from the song reader; 0 = rest, 1..63 = pitch.
REQ-005 SHALL have port duration  input  6  note length in beats.
REQ-006 SHALL have port new_note  input  1  one-cycle load strobe; note/duration are valid in the same cycle.
REQ-007 SHALL have port beat  input  1  one-cycle beat tick.
REQ-008 SHALL have port generate_next_sample  input  1  one-cycle sample-request strobe from the codec side.
REQ-009 SHALL have port note_done  output  1  one-cycle pulse when the loaded note's duration expires.
REQ-010 SHALL have port sample_out  output  16  signed two's-complement audio sample.
REQ-011 SHALL have port new_sample_ready  output  1  one-cycle pulse marking an updated sample_out.

Function
REQ-012 States SHALL be IDLE (no active note) and PLAYING.
REQ-013 new_note high at a clock edge SHALL, at that edge, register note, register duration into count, clear phase to 0 and enter PLAYING, in any state.
REQ-014 new_note SHALL take priority over a same-cycle beat; that beat SHALL NOT decrement the new count.
REQ-015 A new_note during PLAYING SHALL abort the current note without producing note_done for it.
REQ-016 In PLAYING with play=1 and beat=1, count SHALL decrement by 1.
REQ-017 When count is 0 in PLAYING, the block SHALL assert note_done for exactly one cycle and return to IDLE at that edge; a duration-0 load therefore yields note_done 1 cycle after the load edge.
REQ-018 note_done SHALL be registered and SHALL never be high in two consecutive cycles.
REQ-019 With play=0, count, phase and state SHALL hold; beats SHALL be ignored.
REQ-020 step SHALL be a 20-bit value obtained combinationally from the registered note via the step ROM.
REQ-021 On generate_next_sample=1 in PLAYING with play=1, phase SHALL update to phase+step modulo 2^20 (wrap silently).
REQ-022 Triangle magnitude t SHALL be phase[18:3] when phase[19]=0, otherwise bitwise-inverted phase[18:3].
REQ-023 sample_out SHALL be registered as t minus 0x8000 (signed 16-bit) when PLAYING, play=1 and note≠0; otherwise 0.
REQ-024 sample_out SHALL update and new_sample_ready SHALL pulse exactly 1 cycle after every generate_next_sample, in all states, including IDLE, pause and rest.
REQ-025 A rest (note=0) SHALL count beats and produce note_done exactly as a pitched note.

Reset
REQ-026 reset SHALL force state=IDLE, count=0, phase=0, registered note=0, note_done=0, sample_out=0 and new_sample_ready=0 at the next edge.
REQ-027 reset SHALL override new_note, beat and generate_next_sample in the same cycle.
REQ-028 A reset issued mid-note SHALL discard that note and SHALL NOT produce note_done.

Structure
REQ-029 The shared package SHALL hold NOTE_W=6, DUR_W=6, PHASE_W=20, SAMPLE_W=16 and the state encoding.
REQ-030 Step lookup SHALL be the sub-module note_step_rom: combinational, 64×20.
REQ-031 note_step_rom entry 0 SHALL be 0.
REQ-032 note_step_rom entry n SHALL be round(440·2^((n−49)/12)·2^20/48000), giving entry 49 = 9612.
REQ-033 The block SHALL pair directly with the song reader: its note/duration/new_note drive this block's inputs, and this block's note_done drives the song reader.

Verification
REQ-034 Load note=49, duration=3; pulse beat 3 times with play=1 -> note_done high exactly once, 1 cycle after the third beat edge; state returns to IDLE.
REQ-035 Load duration=0 -> note_done pulses on the cycle after load; no sample is non-zero afterwards.
REQ-036 Load note=49; issue 4 generate_next_sample strobes -> phase = 38448 and new_sample_ready pulses 4 times, each 1 cycle after its strobe; after phase reaches 38448, sample_out = 4806−32768 = −27962.
REQ-037 Drop play low mid-note, pulse beat 5 times, raise play -> count unchanged; samples are 0 during the pause and phase resumes from its frozen value.
REQ-038 Assert new_note in the same cycle as beat while a note with duration=2 is playing -> count = new duration; no note_done for the aborted note.
REQ-039 Assert reset with count=2 mid-note -> all outputs 0 on the next cycle; note_done never asserts.
